// File: rtl/conv_mac_if.sv
// Beat and result handshake bundle for conv_mac_array.
// The master drives input beats and result acceptance; the slave is the MAC array.
interface conv_mac_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACCW  = 21
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DW-1:0]     data_fmaps;
  logic [DW-1:0]           data_weight;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ACCW-1:0]   acc_out;

  modport master (
    output in_valid, data_fmaps, data_weight, out_ready,
    input  in_ready, out_valid, acc_out
  );

  modport slave (
    input  in_valid, data_fmaps, data_weight, out_ready,
    output in_ready, out_valid, acc_out
  );
endinterface

// File: rtl/conv_mac_array.sv
// Multi-lane folded convolution MAC: LANES signed accumulators share one weight per beat.
// Each KLEN-beat window closes automatically into a held result register with valid/ready.
module conv_mac_array #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned KLEN  = 9,
  parameter int unsigned ACCW  = 21,
  localparam int unsigned TW   = (KLEN > 1) ? $clog2(KLEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  conv_mac_if.slave     bus,
  output logic [TW-1:0] tap_cnt
);
  localparam int unsigned PW = 2 * DW;

  if (KLEN == 0) begin : g_klen_chk
    $error("conv_mac_array: KLEN must be at least 1");
  end
  if (ACCW < PW + $clog2(KLEN)) begin : g_accw_chk
    $error("conv_mac_array: ACCW too narrow for 2*DW + clog2(KLEN)");
  end

  logic first;
  logic last;
  logic accept;
  logic signed [PW-1:0] weight_x;
  logic [LANES-1:0][ACCW-1:0] res_flat;

  assign first    = (tap_cnt == '0);
  assign last     = (tap_cnt == TW'(KLEN - 1));
  // Only the closing tap waits on a result that has not been taken yet.
  assign bus.in_ready = !clr && !(last && bus.out_valid && !bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign weight_x = PW'($signed(bus.data_weight));

  // Shared tap counter and result-valid flag.
  always_ff @(posedge clk or posedge rst) begin : p_ctrl
    if (rst) begin
      tap_cnt       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (clr) begin
        tap_cnt <= '0;
      end else if (accept) begin
        tap_cnt <= last ? '0 : tap_cnt + TW'(1);
      end
      if (accept && last) begin
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0]   fmap_x;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_x;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] res;

    assign fmap_x = PW'($signed(bus.data_fmaps[i*DW +: DW]));
    assign prod   = fmap_x * weight_x;
    assign prod_x = ACCW'(prod);
    // The first tap loads the product, so no separate clear cycle is needed.
    assign sum    = first ? prod_x : acc + prod_x;

    always_ff @(posedge clk or posedge rst) begin : p_lane
      if (rst) begin
        acc <= '0;
        res <= '0;
      end else if (accept) begin
        if (last) begin
          res <= sum;
        end else begin
          acc <= sum;
        end
      end
    end

    assign res_flat[i] = res;
  end

  assign bus.acc_out = res_flat;
endmodule

// File: doc/conv_mac_array.md
Name: conv_mac_array

Overview:
- Parametrised multi-lane folded convolution MAC; successor to the team's single-lane 8-bit accumulator.
- LANES independent signed accumulators share one broadcast weight per beat; each lane gets its own feature-map sample.
- A tap counter closes each KLEN-beat window automatically; no external output-enable strobe.
- Finished windows go to a registered output stage with valid/ready handshake; accumulation of the next window overlaps with a stalled output.

Parameters:
- DW, 8: signed data width of the feature-map and weight samples.
- LANES, 4: number of parallel accumulator lanes.
- KLEN, 9: taps per window; legal range is 1 or more.
- ACCW, 21: accumulator and output width per lane. Must satisfy ACCW >= 2*DW + clog2(KLEN); enforced by elaboration check.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: asynchronous active-high reset.
- clr, input, 1: synchronous flush of the partial window.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: input beat accepted when in_valid && in_ready.
- data_fmaps, input, LANES*DW: packed signed samples; lane i at bits [i*DW +: DW].
- data_weight, input, DW: signed weight, broadcast to all lanes.
- out_valid, output, 1: result register holds an unconsumed window.
- out_ready, input, 1: downstream accepts the result when out_valid && out_ready.
- acc_out, output, LANES*ACCW: packed signed window sums; lane i at bits [i*ACCW +: ACCW].
- tap_cnt, output, clog2(KLEN) (min 1): index of the next tap to be accepted.

Behaviour:
- Reset (async, any time, including mid-window or while output is stalled):
  - acc_out, out_valid, tap_cnt and all lane accumulators go to 0.
  - Partial window and pending result are discarded.
- Products:
  - prod_i = fmaps_i * data_weight, full 2*DW signed, sign-extended to ACCW.
  - Sums are two's complement; with a legal ACCW no overflow is possible.
- Accept = in_valid && in_ready && !clr.
- On accept with tap_cnt == 0: acc_i <= prod_i. The first tap loads; no separate clear cycle is needed.
- On accept with 0 < tap_cnt < KLEN-1: acc_i <= acc_i + prod_i; tap_cnt increments.
- On accept with tap_cnt == KLEN-1 (last tap):
  - acc_out_i <= acc_i + prod_i (for KLEN=1, prod_i).
  - out_valid <= 1; tap_cnt <= 0.
  - Latency: result visible on the cycle after the last tap is accepted.
- Backpressure: in_ready = !clr && !(tap_cnt == KLEN-1 && out_valid && !out_ready).
  - Only the last tap of a window stalls.
  - Non-final taps keep accumulating while the output is held.
- Output handshake:
  - acc_out and out_valid are held stable while out_valid && !out_ready.
  - If out_ready is high and no last tap is accepted in that cycle, out_valid <= 0.
  - If out_ready is high and a last tap is accepted in the same cycle, the new result loads and out_valid stays 1. This gives full throughput of one window per KLEN beats.
- clr:
  - Sets tap_cnt <= 0. Lane accumulators need not be zeroed because the first-tap load covers it.
  - Forces in_ready low, so a beat presented with clr is not consumed.
  - Does not touch out_valid or acc_out; a pending result still drains normally.
- No internal state changes when in_valid is low; gaps between beats are allowed anywhere in a window.
- Lanes are fully independent apart from the shared weight and the shared tap_cnt.

Test Plan:
- Reset mid-stream: assert rst after 5 of 9 beats with out_valid=1 pending -> same cycle acc_out=0, out_valid=0, tap_cnt=0; next 9 beats give a clean window.
- Basic window (defaults), out_ready=1, 9 beats, weight=2, lane0 fmaps=1..9, lane1 fmaps=-128 with weight replaced by -128 in a separate window -> lane0=90; lane1=147456. With lane2 fmaps=127 and weight=-128 -> lane2=-146304. out_valid pulses 1 cycle after beat 9.
- Backpressure: out_ready=0, continuous in_valid for 18 beats of all-ones data and weight=1:
  - first result=9 and is held.
  - beats 10-17 are accepted.
  - in_ready=0 at beat 18.
  - Raise out_ready -> result 9 is consumed, beat 18 is accepted that same cycle, next cycle acc_out=9 and out_valid stays 1.
- clr mid-window: 4 beats of fmaps=100, weight=1, then clr for 1 cycle with in_valid=1, then 9 beats of fmaps=1 -> single result=9 per lane; the beat presented with clr is not consumed.
- Streaming throughput: continuous in_valid and out_ready=1 for 45 beats -> exactly 5 out_valid pulses, spaced 9 cycles apart, no in_ready deassertion.
- KLEN=1 build: beats every cycle with out_ready toggling 1,0,1,0 -> acc_out equals each product one cycle later; in_ready low exactly on cycles where out_valid=1 and out_ready=0; no result lost or duplicated.
